// File: rtl/button_debouncer.sv
// Multi-button debouncer for the 100 MHz domain. A synchronized 500 Hz tick
// paces per-channel sampling and generates press, release and long-press pulses.
module button_debouncer #(
  parameter int unsigned N_BTN        = 5,
  parameter int unsigned STABLE_TICKS = 10,
  parameter int unsigned LONG_TICKS   = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_clk,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_TICKS - 1);
  localparam logic [15:0] LONG_MAX    = 16'(LONG_TICKS);
  localparam logic [15:0] LONG_LAST   = 16'(LONG_TICKS - 1);

  logic             s1, s2, s3;
  logic             tick;
  logic [N_BTN-1:0] btn_meta, samp;
  logic [N_BTN-1:0] accept;
  logic [7:0]       stable_cnt [N_BTN];
  logic [15:0]      hold_cnt   [N_BTN];

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      btn_meta <= '0;
      samp     <= '0;
    end else begin
      s1       <= tick_clk;
      s2       <= s1;
      s3       <= s2;
      btn_meta <= btn_in;
      samp     <= btn_meta;
    end
  end

  always_comb begin
    tick = s2 & ~s3;
    accept = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      accept[i] = (samp[i] != btn_level[i]) && (stable_cnt[i] == STABLE_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        stable_cnt[i] <= '0;
        hold_cnt[i]   <= '0;
      end
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      if (tick) begin
        for (int unsigned i = 0; i < N_BTN; i++) begin
          if (samp[i] == btn_level[i]) begin
            stable_cnt[i] <= '0;
          end else if (accept[i]) begin
            btn_level[i]   <= samp[i];
            stable_cnt[i]  <= '0;
            btn_press[i]   <= samp[i];
            btn_release[i] <= ~samp[i];
          end else begin
            stable_cnt[i] <= stable_cnt[i] + 8'd1;
          end

          // The accepting tick clears the hold count, so a release can never
          // coincide with a long pulse and a new press always starts from 0.
          if (accept[i] || !btn_level[i]) begin
            hold_cnt[i] <= '0;
          end else if (hold_cnt[i] != LONG_MAX) begin
            hold_cnt[i] <= hold_cnt[i] + 16'd1;
            if (hold_cnt[i] == LONG_LAST) begin
              btn_long[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus queues expected pulse events
// keyed by tick_clk rise index; a monitor pops and compares on every pulse.
module tb_button_debouncer;

  localparam int unsigned NB = 5;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          tick_clk = 1'b0;
  logic [NB-1:0] btn_in   = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;

  button_debouncer #(
    .N_BTN(NB),
    .STABLE_TICKS(10),
    .LONG_TICKS(500)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick_clk(tick_clk),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_long(btn_long)
  );

  typedef struct {
    int unsigned   tick;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] lng;
    logic [NB-1:0] level;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         cur;
  int unsigned n_cmp    = 0;
  int unsigned n_bad    = 0;
  int unsigned rise_cnt = 0;
  int unsigned edges    = 0;

  // tick_clk edges land on clk falling edges, never on the active edge.
  always #5 clk = ~clk;
  always #50 tick_clk = ~tick_clk;

  always @(posedge tick_clk) begin
    rise_cnt++;
    edges = 0;
  end

  always @(posedge clk) edges++;

  always @(negedge clk) begin
    if ((btn_press | btn_release | btn_long) != '0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got press=%b release=%b long=%b at tick %0d, required no pulse",
                 btn_press, btn_release, btn_long, rise_cnt);
      end else begin
        cur = exp_q.pop_front();
        if (cur.tick != rise_cnt || edges != 3 || cur.press != btn_press ||
            cur.rel != btn_release || cur.lng != btn_long || cur.level != btn_level) begin
          n_bad++;
          $display("FAIL event: got tick=%0d lat=%0d press=%b rel=%b long=%b level=%b, required tick=%0d lat=3 press=%b rel=%b long=%b level=%b",
                   rise_cnt, edges, btn_press, btn_release, btn_long, btn_level,
                   cur.tick, cur.press, cur.rel, cur.lng, cur.level);
        end
      end
    end
  end

  task automatic expect_ev(input int unsigned t, input logic [NB-1:0] p, input logic [NB-1:0] r,
                           input logic [NB-1:0] l, input logic [NB-1:0] lv);
    ev_t e;
    e.tick  = t;
    e.press = p;
    e.rel   = r;
    e.lng   = l;
    e.level = lv;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {12'd0, btn_level, btn_press, btn_release, btn_long}, 32'd0);
  endtask

  // A slot is just after a tick_clk fall; inputs changed here are first
  // seen by the tick of the following rise.
  task automatic slot();
    @(negedge tick_clk);
    #1;
  endtask

  task automatic slots(input int unsigned n);
    repeat (n) slot();
  endtask

  initial begin
    int unsigned r;

    reset  = 1'b0;
    btn_in = '0;
    repeat (3) begin
      slot();
      check_zero("reset_outputs");
    end
    reset = 1'b1;
    slots(5);
    check("idle_level", 32'(btn_level), 32'd0);

    // clean press on channel 0, held 30 ticks
    slot();
    r = rise_cnt;
    btn_in[0] = 1'b1;
    expect_ev(r + 10, 5'b00001, 5'b00000, 5'b00000, 5'b00001);
    slots(30);
    btn_in[0] = 1'b0;
    expect_ev(r + 40, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
    slots(15);

    // bouncy press on channel 1: six alternating samples, then stable 1
    slot();
    r = rise_cnt;
    btn_in[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      slot();
      btn_in[1] = (k % 2 == 0);
    end
    expect_ev(r + 16, 5'b00010, 5'b00000, 5'b00000, 5'b00010);
    slots(14);
    check("bouncy_level", 32'(btn_level), 32'h02);
    btn_in[1] = 1'b0;
    expect_ev(r + 30, 5'b00000, 5'b00010, 5'b00000, 5'b00000);
    slots(15);

    // glitches of 5 and 9 samples rejected, then exactly 10 accepted
    slot();
    btn_in[2] = 1'b1;
    slots(5);
    btn_in[2] = 1'b0;
    slots(3);
    btn_in[2] = 1'b1;
    slots(9);
    btn_in[2] = 1'b0;
    slots(3);
    check("glitch_level", 32'(btn_level), 32'd0);
    r = rise_cnt;
    btn_in[2] = 1'b1;
    expect_ev(r + 10, 5'b00100, 5'b00000, 5'b00000, 5'b00100);
    slots(10);
    btn_in[2] = 1'b0;
    expect_ev(r + 20, 5'b00000, 5'b00100, 5'b00000, 5'b00000);
    slots(15);

    // simultaneous press and release on channels 0 and 1
    slot();
    r = rise_cnt;
    btn_in[1:0] = 2'b11;
    expect_ev(r + 10, 5'b00011, 5'b00000, 5'b00000, 5'b00011);
    slots(20);
    btn_in[1:0] = 2'b00;
    expect_ev(r + 30, 5'b00000, 5'b00011, 5'b00000, 5'b00000);
    slots(15);

    // long press on channel 3, held 600 ticks
    slot();
    r = rise_cnt;
    btn_in[3] = 1'b1;
    expect_ev(r + 10, 5'b01000, 5'b00000, 5'b00000, 5'b01000);
    expect_ev(r + 510, 5'b00000, 5'b00000, 5'b01000, 5'b01000);
    slots(300);
    check("long_mid_level", 32'(btn_level), 32'h08);
    slots(300);
    btn_in[3] = 1'b0;
    expect_ev(r + 610, 5'b00000, 5'b01000, 5'b00000, 5'b00000);
    slots(15);

    // reset after 7 counted samples on channel 4, button held through reset
    slot();
    btn_in[4] = 1'b1;
    slots(7);
    reset = 1'b0;
    slot();
    check_zero("mid_reset_1");
    slot();
    check_zero("mid_reset_2");
    reset = 1'b1;
    r = rise_cnt;
    expect_ev(r + 10, 5'b10000, 5'b00000, 5'b00000, 5'b10000);
    slots(15);
    btn_in[4] = 1'b0;
    expect_ev(r + 25, 5'b00000, 5'b10000, 5'b00000, 5'b00000);
    slots(15);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
